mul_seq_shift_add: RTL and testbench

- Sequential unsigned WIDTH x WIDTH shift-and-add multiplier for the ALU multiply operation.
- Sits downstream of the operand registers and upstream of the ALU result mux.
- Uses a WIDTH-bit ripple-carry adder to accumulate partial products, one multiplier bit per clock.
- Produces a 2*WIDTH-bit product plus a zero flag, using a START/BUSY/DONE handshake.

---
 rtl/mul_seq_shift_add_pkg.sv | 21 ++
 rtl/mul_seq_shift_add_add_ripple_w.sv | 30 +++
 rtl/mul_seq_shift_add.sv | 123 ++++++++++++
 tb/tb_mul_seq_shift_add.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_shift_add_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   - state_t   : FSM encoding (IDLE, CALC, DONE)
//   - DEFAULT_WIDTH : default operand width
//   - cnt_width : width of the iteration counter for a given operand width
package mul_seq_shift_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The counter only has to hold 0..WIDTH-1; a 1-bit floor keeps tiny
  // widths from producing a zero-width vector.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mul_seq_shift_add_add_ripple_w.sv
// WIDTH-bit ripple-carry adder, carry-in tied to 0.
//   a, b      : addends
//   sum       : WIDTH-bit sum
//   carry_out : carry out of the top bit
module mul_seq_shift_add_add_ripple_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH:0] carry;

  assign carry[0]  = 1'b0;
  assign carry_out = carry[WIDTH];

  // One full-adder cell per bit, each built from plain XOR/AND/OR gates so
  // the carry chain ripples from bit 0 upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic prop;
    logic gen;
    assign prop         = a[i] ^ b[i];
    assign gen          = a[i] & b[i];
    assign sum[i]       = prop ^ carry[i];
    assign carry[i+1]   = gen | (prop & carry[i]);
  end

endmodule

// File: rtl/mul_seq_shift_add.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : request, sampled only in IDLE
//   a, b      : multiplicand / multiplier, captured when start is accepted
//   busy      : registered, high while the FSM is in CALC or DONE
//   done      : registered one-cycle pulse, resultado valid from then on
//   resultado : 2*WIDTH-bit product, held until the next completion
//   zero      : high when resultado is zero
module mul_seq_shift_add
  import mul_seq_shift_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   resultado,
  output logic                 zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t               state;
  state_t               next_state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     acc_hi;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 carry;
  logic [CW-1:0]        cnt;
  logic                 last_iter;
  logic [2*WIDTH-1:0]   shifted;

  // Partial product for this iteration: the multiplicand when the current
  // multiplier LSB is set. The carry-out becomes the new top bit after the
  // right shift, so the accumulator can never overflow.
  assign addend    = mplier[0] ? mcand : '0;
  assign shifted   = {carry, sum, mplier[WIDTH-1:1]};
  assign last_iter = (cnt == CW'(WIDTH - 1));

  mul_seq_shift_add_add_ripple_w #(
    .WIDTH(WIDTH)
  ) u_add (
    .a        (acc_hi),
    .b        (addend),
    .sum      (sum),
    .carry_out(carry)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: WIDTH iterations in CALC, one cycle in DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (last_iter) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, shift-and-add iteration and result latch. The result
  // is taken from the post-shift value on the edge that enters DONE, so the
  // final iteration is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc_hi    <= '0;
      cnt       <= '0;
      resultado <= '0;
      zero      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc_hi <= shifted[2*WIDTH-1:WIDTH];
          mplier <= shifted[WIDTH-1:0];
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            resultado <= shifted;
            zero      <= (shifted == '0);
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs are registered decodes of the current state, so they
  // trail the state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state == CALC) || (state == DONE);
      done <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_mul_seq_shift_add.sv
// Self-checking bench for mul_seq_shift_add (WIDTH = 8). Expected products
// come from plain integer multiplication; expected timing from the fixed
// WIDTH+1 cycle latency and WIDTH+2 cycle restart period.
module tb_mul_seq_shift_add;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] resultado;
  logic           zero;

  int checks;
  int failures;

  int n;
  int doneCount;
  int firstDone;
  int lastDone;
  int gapErrors;
  int consecCount;
  logic prevDone;
  logic [2*W-1:0] lastResult;

  mul_seq_shift_add #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .resultado(resultado),
    .zero     (zero)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case a wait ever runs away.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference product straight from integer arithmetic.
  function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] x, input logic [W-1:0] y);
    return (2*W)'(x) * (2*W)'(y);
  endfunction

  // Issue one START pulse and check latency, product, zero flag and the
  // busy/done behaviour around completion.
  task automatic applyStimulus(input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                               input string tag);
    logic [2*W-1:0] expected;
    int cyc;
    expected = refProduct(aIn, bIn);
    @(negedge clk);
    a = aIn;
    b = bIn;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cyc = 0;
    while (!done && cyc < 3 * W) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc == 2) checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    end
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(W + 1));
    checkOutput({tag, "_result"}, 32'(resultado), 32'(expected));
    checkOutput({tag, "_zero"}, 32'(zero), 32'(expected == '0));
    @(negedge clk);
    checkOutput({tag, "_done_drop"}, 32'(done), 32'd0);
    checkOutput({tag, "_busy_drop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    rst_n    = 1'b1;

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_result", 32'(resultado), 32'd0);
    checkOutput("reset_zero", 32'(zero), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle with START low: no completion expected.
    doneCount = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("idle_no_done", 32'(doneCount), 32'd0);

    // Directed products.
    applyStimulus(8'h0D, 8'h0B, "p_0d_0b");
    applyStimulus(8'hFF, 8'hFF, "p_ff_ff");
    applyStimulus(8'h00, 8'h5A, "p_00_5a");
    applyStimulus(8'h5A, 8'h00, "p_5a_00");

    // START re-pulsed mid-calculation must be ignored.
    @(negedge clk);
    a = 8'h10;
    b = 8'h10;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    doneCount = 0;
    firstDone = 0;
    lastResult = '0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) begin
        a = 8'h02;
        b = 8'h03;
        start = 1'b1;
      end
      if (k == 4) start = 1'b0;
      if (done) begin
        doneCount++;
        if (firstDone == 0) begin
          firstDone  = k;
          lastResult = resultado;
        end
      end
    end
    checkOutput("ignore_done_count", 32'(doneCount), 32'd1);
    checkOutput("ignore_latency", 32'(firstDone), 32'(W + 1));
    checkOutput("ignore_result", 32'(lastResult), 32'(refProduct(8'h10, 8'h10)));

    // START held high: back-to-back products every WIDTH+2 cycles.
    @(negedge clk);
    a = 8'h03;
    b = 8'h05;
    start = 1'b1;
    doneCount   = 0;
    firstDone   = 0;
    lastDone    = 0;
    gapErrors   = 0;
    consecCount = 0;
    prevDone    = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done && prevDone) consecCount++;
      if (done) begin
        doneCount++;
        if (firstDone == 0) firstDone = k;
        else if (k - lastDone != W + 2) gapErrors++;
        lastDone = k;
        checkOutput("held_result", 32'(resultado), 32'(refProduct(8'h03, 8'h05)));
      end
      prevDone = done;
    end
    start = 1'b0;
    checkOutput("held_first_done", 32'(firstDone), 32'(W + 2));
    checkOutput("held_done_count", 32'(doneCount), 32'd3);
    checkOutput("held_gap_errors", 32'(gapErrors), 32'd0);
    checkOutput("held_consecutive", 32'(consecCount), 32'd0);
    repeat (3 * W) @(negedge clk);

    // Reset during CALC aborts the operation and clears the result.
    @(negedge clk);
    a = 8'h80;
    b = 8'h02;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_result", 32'(resultado), 32'd0);
    checkOutput("abort_zero", 32'(zero), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    repeat (2 * W + 4) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("abort_no_done", 32'(doneCount), 32'd0);
    checkOutput("abort_result_held", 32'(resultado), 32'd0);
    applyStimulus(8'h80, 8'h02, "p_after_abort");

    // Reset released with START already high: accepted on the first edge.
    @(negedge clk);
    rst_n = 1'b0;
    a = 8'h80;
    b = 8'h02;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!done && n < 3 * W) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
    end
    checkOutput("release_latency", 32'(n), 32'(W + 2));
    checkOutput("release_result", 32'(resultado), 32'(refProduct(8'h80, 8'h02)));
    repeat (2) @(negedge clk);

    // Randomised products with random idle gaps, corners mixed in.
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 5) == 0) ra = '1;
      if ($urandom_range(0, 7) == 0) rb = '0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(ra, rb, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
